// File: rtl/dp_types_pkg.sv
// Shared datapath types for pipeline stages: stage occupancy state and an example payload
// that callers size through $bits() when instantiating pipe_stage_reg.
package dp_types_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } pstage_state_t;

  // Example IF/ID payload; 64 bits wide to match the stage's default WIDTH.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle around one pipeline stage: the upstream side (in_*) and the
// downstream side (out_*). The stage uses the slave modport; its environment uses master.
interface pipe_stage_reg_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Registered pipeline stage with optional two-entry skid buffer, synchronous flush and a
// saturating count of back-pressured cycles. Payload type is opaque; size it with $bits().
module pipe_stage_reg
  import dp_types_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SKID  = 1,
  parameter int CNT_W = 32
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 flush,
  pipe_stage_reg_if.slave      bus,
  output logic [CNT_W-1:0]     stall_cnt
);

  pstage_state_t    state_q, state_d;
  logic [WIDTH-1:0] main_q,  main_d;
  logic [WIDTH-1:0] skid_q,  skid_d;

  logic out_valid;
  logic in_ready;
  logic accept;
  logic emit;

  assign out_valid = (state_q != EMPTY);
  assign accept    = bus.in_valid & in_ready;
  assign emit      = out_valid & bus.out_ready;

  // With a skid entry in_ready depends only on state; without it, a full stage may still
  // accept in the same cycle its occupant leaves, which makes in_ready follow out_ready.
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = (state_q != FULL);
    end else begin : g_noskid
      assign in_ready = ~out_valid | bus.out_ready;
    end
  endgenerate

  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = HALF;
            main_d  = bus.in_data;
          end
        end
        HALF: begin
          if (accept && emit) begin
            main_d = bus.in_data;
          end else if (accept && (SKID != 0)) begin
            state_d = FULL;
            skid_d  = bus.in_data;
          end else if (emit) begin
            state_d = EMPTY;
            main_d  = '0;
          end
        end
        FULL: begin
          if (emit) begin
            state_d = HALF;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // NOTE: payload registers are reset too: out_data is driven straight from main_q and must
  // read 0 whenever the stage is empty, including right after nRST.
  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!nRST) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = main_q;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .CLK    (CLK),
    .nRST   (nRST),
    .inc_i  (out_valid & ~bus.out_ready),
    .count_o(stall_cnt)
  );

endmodule
